fetch_decode_unit: RTL and testbench
====================================

// Module: fetch_decode_unit
// PURPOSE
// - Front end of the K&S datapath: holds PC and IR, selects the RAM address, decodes IR into decoded_instruction.
// - Also produces the register-file address fields.
// - Driven by the control FSM (branch, pc_enable, ir_enable, addr_sel); its decoded_instruction feeds that FSM's DECODE state.
// - Adds a retired-instruction counter and a sticky illegal-opcode flag for debug.
// PARAMETERS
// ADDR_W    8      RAM address / PC width
// DATA_W    16     instruction / RAM word width
// RESET_PC  0      PC value after reset
// CNT_W     16     width of retired-instruction counter
// PORTS
// clk                 in   1       clock, all state on rising edge
// rst                 in   1       asynchronous, active-high reset
// branch              in   1       PC load source: 1 = IR target, 0 = PC+1
// pc_enable           in   1       PC update strobe
// ir_enable           in   1       IR capture strobe
// addr_sel            in   1       mem_addr source: 1 = IR[ADDR_W-1:0], 0 = PC
// mem_data_in         in   DATA_W  RAM read data (1-cycle synchronous read)
// mem_addr            out  ADDR_W  RAM address
// decoded_instruction out  decoded_instruction_type  opcode decode of IR (k_and_s_pkg)
// a_addr              out  2       register-file read port A
// b_addr              out  2       register-file read port B
// c_addr              out  2       register-file write port C
// pc_out              out  ADDR_W  current PC (debug)
// ir_out              out  DATA_W  current IR (debug)
// instr_count         out  CNT_W   instructions fetched since reset, saturating
// illegal_op          out  1       sticky: an undefined opcode was captured
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset: PC=RESET_PC, IR=0 (decodes I_NOP), instr_count=0, illegal_op=0.
//   - Outputs follow combinationally: mem_addr=RESET_PC, a/b/c_addr=0.
//   - Reset mid-operation discards any pending update; no capture on the edge rst deasserts.
// - IR: when ir_enable, IR <= mem_data_in; otherwise IR holds.
// - PC: when pc_enable:
//   - branch=1: PC <= IR[ADDR_W-1:0], using the pre-edge IR.
//   - branch=0: PC <= PC+1, wrapping 2^ADDR_W-1 -> 0 with no flag.
//   - pc_enable=0: PC holds; branch is ignored.
// - Simultaneous ir_enable and pc_enable with branch=0 is the normal fetch step.
//   - IR takes the word addressed by the old PC; PC increments.
//   - The branch target always comes from the old IR, never mem_data_in.
// - mem_addr = addr_sel ? IR[ADDR_W-1:0] : PC; purely combinational.
// - RAM latency is 1 cycle: the address presented in the fetch cycle gives data captured in the next (ir_enable) cycle.
// - Encoding: IR[15:11] opcode.
//   - 00001 LOAD, 00010 STORE, 00011 MOVE.
//   - 00100 ADD, 00101 SUB, 00110 AND, 00111 OR.
//   - 01000 BRANCH, 01001 BZERO, 01010 BNZERO, 01011 BNEG, 01100 BNNEG, 01101 BOV, 01110 BNOV.
//   - 11111 HALT; 00000 NOP; any other opcode -> I_NOP.
// - Register fields; any field not listed is 0:
//   - ADD/SUB/AND/OR: c=IR[5:4], a=IR[3:2], b=IR[1:0].
//   - MOVE: c=IR[5:4], a=b=IR[3:2] (ALU AND of a value with itself).
//   - LOAD: c=IR[9:8].
//   - STORE: a=IR[9:8].
// - Decode and register fields are combinational from registered IR.
// - instr_count: +1 on each ir_enable edge; saturates at all-ones.
// - illegal_op: set on an ir_enable edge whose captured opcode is undefined (not NOP/listed); cleared only by rst.
// TESTING
// - Reset then RAM[0]=16'h2076 (ADD c=3,a=1,b=2): 1 fetch cycle + ir_enable&pc_enable -> ir_out=2076, decoded=I_ADD, c/a/b=3/1/2, PC=1, instr_count=1.
// - IR=16'h4042 (BRANCH 0x42), pc_enable=1, branch=1 -> PC=0x42; same with branch=0 -> PC=old+1.
// - PC=8'hFF, pc_enable=1, branch=0 -> PC=8'h00, illegal_op unchanged.
// - IR=16'h0915 (LOAD r1,0x15), addr_sel=1 -> mem_addr=0x15, c_addr=1; addr_sel=0 -> mem_addr=PC.
// - Capture 16'h8000 (opcode 10000) -> decoded=I_NOP, illegal_op=1 and stays 1 after a later valid fetch; rst -> 0.
// - Assert rst while ir_enable=pc_enable=1 -> PC, IR and count reset immediately; no capture on the release edge.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// K&S datapath front end: PC/IR registers, RAM address mux and instruction decode,
// plus a saturating fetch counter and a sticky illegal-opcode flag for debug.
package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

module fetch_decode_unit
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic [DATA_W-1:0]       mem_data_in,
    output logic [ADDR_W-1:0]       mem_addr,
    output decoded_instruction_type decoded_instruction,
    output logic [1:0]              a_addr,
    output logic [1:0]              b_addr,
    output logic [1:0]              c_addr,
    output logic [ADDR_W-1:0]       pc_out,
    output logic [DATA_W-1:0]       ir_out,
    output logic [CNT_W-1:0]        instr_count,
    output logic                    illegal_op
);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [CNT_W-1:0]  cnt;
    logic              ill;
    logic [4:0]        opcode;
    logic [4:0]        cap_op;
    logic              cap_legal;

    assign opcode = ir[DATA_W-1 -: 5];
    assign cap_op = mem_data_in[DATA_W-1 -: 5];
    // Defined opcodes are the contiguous block 0..14 plus HALT.
    assign cap_legal = (cap_op <= 5'd14) || (cap_op == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= PC_RST;
            ir  <= '0;
            cnt <= '0;
            ill <= 1'b0;
        end else begin
            if (ir_enable) begin
                ir <= mem_data_in;
                if (cnt != '1)
                    cnt <= cnt + 1'b1;
                if (!cap_legal)
                    ill <= 1'b1;
            end
            // Branch target is the pre-edge IR, never the word being captured.
            if (pc_enable)
                pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
        end
    end

    assign mem_addr    = addr_sel ? ir[ADDR_W-1:0] : pc;
    assign pc_out      = pc;
    assign ir_out      = ir;
    assign instr_count = cnt;
    assign illegal_op  = ill;

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr = 2'd0;
        b_addr = 2'd0;
        c_addr = 2'd0;
        case (opcode)
            5'b00001: begin
                decoded_instruction = I_LOAD;
                c_addr = ir[9:8];
            end
            5'b00010: begin
                decoded_instruction = I_STORE;
                a_addr = ir[9:8];
            end
            // MOVE is executed as an ALU AND of the source with itself.
            5'b00011: begin
                decoded_instruction = I_MOVE;
                c_addr = ir[5:4];
                a_addr = ir[3:2];
                b_addr = ir[3:2];
            end
            5'b00100, 5'b00101, 5'b00110, 5'b00111: begin
                case (opcode[1:0])
                    2'b00:   decoded_instruction = I_ADD;
                    2'b01:   decoded_instruction = I_SUB;
                    2'b10:   decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                c_addr = ir[5:4];
                a_addr = ir[3:2];
                b_addr = ir[1:0];
            end
            5'b01000: decoded_instruction = I_BRANCH;
            5'b01001: decoded_instruction = I_BZERO;
            5'b01010: decoded_instruction = I_BNZERO;
            5'b01011: decoded_instruction = I_BNEG;
            5'b01100: decoded_instruction = I_BNNEG;
            5'b01101: decoded_instruction = I_BOV;
            5'b01110: decoded_instruction = I_BNOV;
            5'b11111: decoded_instruction = I_HALT;
            default:  decoded_instruction = I_NOP;
        endcase
    end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Randomized scoreboard bench for fetch_decode_unit with a synchronous-read RAM model
// and a behavioural reference of PC/IR/decode/counter/flag behaviour.
module tb_fetch_decode_unit;
    import k_and_s_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic [7:0]              pc;
        logic [15:0]             ir;
        logic [CW-1:0]           cnt;
        logic                    ill;
        logic [7:0]              maddr;
        decoded_instruction_type dec;
        logic [1:0]              a, b, c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0, addr_sel = 1'b0;
    logic [15:0] mem_data_in = '0;
    logic [7:0]  mem_addr;
    decoded_instruction_type decoded_instruction;
    logic [1:0]  a_addr, b_addr, c_addr;
    logic [7:0]  pc_out;
    logic [15:0] ir_out;
    logic [CW-1:0] instr_count;
    logic        illegal_op;

    fetch_decode_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(0), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable),
        .ir_enable(ir_enable), .addr_sel(addr_sel), .mem_data_in(mem_data_in),
        .mem_addr(mem_addr), .decoded_instruction(decoded_instruction),
        .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr), .pc_out(pc_out),
        .ir_out(ir_out), .instr_count(instr_count), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [256];
    always @(posedge clk) mem_data_in <= ram[mem_addr];

    int total = 0;
    int bad = 0;
    exp_t sb_q[$];

    // Reference state
    decoded_instruction_type op_tbl [32];
    logic [7:0]    m_pc;
    logic [15:0]   m_ir;
    int            m_cnt;
    logic          m_ill;
    logic [15:0]   m_rd;

    function automatic exp_t model_out(input logic asel);
        exp_t e;
        decoded_instruction_type d;
        d = op_tbl[m_ir[15:11]];
        e.pc = m_pc; e.ir = m_ir; e.cnt = CW'(m_cnt); e.ill = m_ill;
        e.maddr = asel ? m_ir[7:0] : m_pc;
        e.dec = d; e.a = 2'd0; e.b = 2'd0; e.c = 2'd0;
        if (d == I_ADD || d == I_SUB || d == I_AND || d == I_OR) begin
            e.c = m_ir[5:4]; e.a = m_ir[3:2]; e.b = m_ir[1:0];
        end else if (d == I_MOVE) begin
            e.c = m_ir[5:4]; e.a = m_ir[3:2]; e.b = m_ir[3:2];
        end else if (d == I_LOAD) begin
            e.c = m_ir[9:8];
        end else if (d == I_STORE) begin
            e.a = m_ir[9:8];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_pc = 8'd0; m_ir = 16'd0; m_cnt = 0; m_ill = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, queue the post-edge expectation.
    task automatic step(input logic r, input logic ire, input logic pce,
                        input logic br, input logic asel);
        logic [7:0] cur_addr;
        logic [15:0] old_ir;
        rst = r; ir_enable = ire; pc_enable = pce; branch = br; addr_sel = asel;
        if (r) model_reset();
        cur_addr = asel ? m_ir[7:0] : m_pc;
        if (!r) begin
            old_ir = m_ir;
            if (ire) begin
                m_ir = m_rd;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (op_tbl[m_rd[15:11]] == I_NOP && m_rd[15:11] != 5'd0) m_ill = 1'b1;
            end
            if (pce) m_pc = br ? old_ir[7:0] : m_pc + 8'd1;
        end
        m_rd = ram[cur_addr];
        sb_q.push_back(model_out(asel));
        @(posedge clk);
        #4;
    endtask

    // Monitor: outputs are valid every cycle; check each queued expectation after its edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (pc_out !== e.pc || ir_out !== e.ir || instr_count !== e.cnt ||
                    illegal_op !== e.ill || mem_addr !== e.maddr ||
                    decoded_instruction !== e.dec || a_addr !== e.a ||
                    b_addr !== e.b || c_addr !== e.c) begin
                    bad++;
                    $display("FAIL cycle @%0t: got pc=%h ir=%h cnt=%0d ill=%b ma=%h dec=%s a/b/c=%0d/%0d/%0d want pc=%h ir=%h cnt=%0d ill=%b ma=%h dec=%s a/b/c=%0d/%0d/%0d",
                             $time, pc_out, ir_out, instr_count, illegal_op, mem_addr,
                             decoded_instruction.name(), a_addr, b_addr, c_addr,
                             e.pc, e.ir, e.cnt, e.ill, e.maddr, e.dec.name(), e.a, e.b, e.c);
                end
            end
        end
    end

    initial begin
        decoded_instruction_type defined [14] = '{I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB,
            I_AND, I_OR, I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};
        foreach (op_tbl[i]) op_tbl[i] = I_NOP;
        for (int i = 0; i < 14; i++) op_tbl[i + 1] = defined[i];
        op_tbl[31] = I_HALT;
        foreach (ram[i]) ram[i] = 16'(($urandom % 15) << 11) | 16'($urandom_range(0, 2047));
        ram[8'h00] = 16'h2076;
        ram[8'h01] = 16'h4042;
        ram[8'h43] = 16'h0915;
        ram[8'h44] = 16'h8000;
        ram[8'h45] = 16'h40FF;
        model_reset();
        m_rd = 16'd0;

        #2;
        chk("reset_pc", 32'(pc_out), 32'h0);
        chk("reset_ir", 32'(ir_out), 32'h0);
        chk("reset_maddr", 32'(mem_addr), 32'h0);
        chk("reset_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk("reset_abc", {26'd0, a_addr, b_addr, c_addr}, 32'h0);

        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);              // fetch cycle: RAM[0] read
        step(0, 1, 1, 0, 0);              // capture ADD, PC+1
        chk("add_ir", 32'(ir_out), 32'h2076);
        chk("add_dec", 32'(decoded_instruction), 32'(I_ADD));
        chk("add_cab", {26'd0, c_addr, a_addr, b_addr}, {26'd0, 2'd3, 2'd1, 2'd2});
        chk("add_pc", 32'(pc_out), 32'h1);
        chk("add_cnt", 32'(instr_count), 32'h1);

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);              // IR = BRANCH 0x42
        step(0, 0, 1, 1, 0);
        chk("branch_pc", 32'(pc_out), 32'h42);
        step(0, 0, 1, 0, 0);
        chk("nobranch_pc", 32'(pc_out), 32'h43);

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);              // IR = LOAD r1,0x15
        step(0, 0, 0, 0, 1);
        chk("load_maddr", 32'(mem_addr), 32'h15);
        chk("load_c", 32'(c_addr), 32'h1);
        chk("load_dec", 32'(decoded_instruction), 32'(I_LOAD));
        step(0, 0, 0, 0, 0);
        chk("pc_maddr", 32'(mem_addr), 32'h44);

        step(0, 1, 1, 0, 0);              // capture 0x8000
        chk("illegal_dec", 32'(decoded_instruction), 32'(I_NOP));
        chk("illegal_set", 32'(illegal_op), 32'h1);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);              // valid BRANCH 0xFF
        chk("illegal_sticky", 32'(illegal_op), 32'h1);
        step(0, 0, 1, 1, 0);
        chk("pc_ff", 32'(pc_out), 32'hFF);
        step(0, 0, 1, 0, 0);
        chk("pc_wrap", 32'(pc_out), 32'h0);
        chk("wrap_ill", 32'(illegal_op), 32'h1);

        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0);
        chk("cnt_sat", 32'(instr_count), 32'((1 << CW) - 1));

        // Asynchronous reset in the middle of a fetch step.
        ir_enable = 1'b1; pc_enable = 1'b1; addr_sel = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_pc", 32'(pc_out), 32'h0);
        chk("async_ir", 32'(ir_out), 32'h0);
        chk("async_cnt", 32'(instr_count), 32'h0);
        chk("async_ill", 32'(illegal_op), 32'h0);
        step(1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("post_rst_cnt", 32'(instr_count), 32'h0);

        foreach (ram[i]) ram[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 50) == 0, 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end
        step(0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
